// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 16;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] rdata;
  } rsp_t;

  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the arbiter. A request k is accepted in a
// cycle where i_req_valid[k] & o_req_ready[k]; the requester holds every field
// stable until then and never drops valid before acceptance.
interface mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [1:0]        i_req_valid;
  logic [1:0]        o_req_ready;
  logic [ADDR_W-1:0] i_req_addr  [2];
  logic [1:0]        i_req_we;
  logic [DATA_W-1:0] i_req_wdata [2];
  logic [3:0]        i_req_bmask [2];
  logic [1:0]        i_req_lock;
  logic [1:0]        o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_rdata [2];
  logic              o_lock_abort;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_bmask, i_req_lock,
    input  i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_lock_abort,
    output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_bmask, i_req_lock,
    output i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_lock_abort,
    input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant, restricted to the owner while locked.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  input  logic       locked,
  input  logic       owner,
  output logic [1:0] grant
);
  logic [1:0] mask;
  logic [1:0] cand;

  always_comb begin
    mask  = locked ? (owner ? 2'b10 : 2'b01) : 2'b11;
    cand  = valid & mask;
    grant = cand;
    if (cand == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-masked data memory between the core (req 0) and the loader
// (req 1) with round-robin fairness and a bounded bus lock.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_arbiter_if.slave  bus,
  output arb_state_t    o_dbg_state
);
  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(LOCK_MAX - 2);

  arb_state_t       state;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_abort_q;
  rsp_t             rsp_q [2];

  logic [1:0] valid_gated;
  logic [1:0] grant;
  logic       gid;
  logic       any_grant;
  logic       lock_release;

  // Nothing is accepted while reset is asserted.
  assign valid_gated = bus.i_req_valid & {2{i_reset}};

  rr_arb2 u_pick (
    .valid  (valid_gated),
    .rr_ptr (rr_ptr),
    .locked (state == LOCKED),
    .owner  (owner),
    .grant  (grant)
  );

  assign gid          = grant[1];
  assign any_grant    = |grant;
  assign lock_release = any_grant && !bus.i_req_lock[gid];

  assign bus.o_req_ready  = grant;
  assign bus.o_rsp_valid  = {rsp_q[1].valid, rsp_q[0].valid};
  assign bus.o_rsp_rdata[0] = rsp_q[0].rdata;
  assign bus.o_rsp_rdata[1] = rsp_q[1].rdata;
  assign bus.o_lock_abort = lock_abort_q;
  assign o_dbg_state      = state;

  always_comb begin
    bus.o_mem_addr  = {ADDR_W{1'b0}};
    bus.o_mem_wdata = {DATA_W{1'b0}};
    bus.o_mem_bmask = 4'b0000;
    bus.o_mem_wren  = 1'b0;
    if (any_grant) begin
      bus.o_mem_addr  = bus.i_req_addr[gid];
      bus.o_mem_wdata = bus.i_req_wdata[gid];
      bus.o_mem_bmask = bus.i_req_bmask[gid];
      bus.o_mem_wren  = bus.i_req_we[gid];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= ARB;
      rr_ptr       <= REQ_CORE;
      owner        <= REQ_CORE;
      lock_cnt     <= '0;
      lock_abort_q <= 1'b0;
      for (int k = 0; k < 2; k++) rsp_q[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        rsp_q[k].valid <= grant[k];
        rsp_q[k].rdata <= (grant[k] && !bus.i_req_we[k]) ? bus.i_mem_rdata : '0;
      end
      // Raised one cycle early so the pulse coincides with the final locked cycle.
      lock_abort_q <= (state == LOCKED) && (lock_cnt == CNT_PRE) && !lock_release;
      unique case (state)
        ARB: begin
          if (any_grant) begin
            rr_ptr <= other_req(gid);
            if (bus.i_req_lock[gid]) begin
              state    <= LOCKED;
              owner    <= gid;
              lock_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          lock_cnt <= lock_cnt + CNT_W'(1);
          if ((lock_cnt == CNT_LAST) || lock_release) begin
            state  <= ARB;
            rr_ptr <= other_req(owner);
          end
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, byte-addressable data memory between the core load/store path (requester 0) and a program/debug loader (requester 1). Grants at most one access per cycle with round-robin fairness, supports a bounded bus lock for loader bursts, and returns registered read data and a write acknowledge one cycle after acceptance. Sits between the requesters and the data memory: asynchronous read, synchronous byte-masked write.

## Interface
- ADDR_W, 11, byte address width into memory
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release (≥2)
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_req_valid[k], k=0..1  in  1  request valid
- o_req_ready[k]  out  1  request accepted this cycle (combinational grant)
- i_req_addr[k]  in  ADDR_W  byte address
- i_req_we[k]  in  1  1=write, 0=read
- i_req_wdata[k]  in  DATA_W  write data
- i_req_bmask[k]  in  4  byte enables, already lane-aligned
- i_req_lock[k]  in  1  hold ownership after this transaction
- o_rsp_valid[k]  out  1  one-cycle response pulse
- o_rsp_rdata[k]  out  DATA_W  registered read data (0 for writes)
- o_lock_abort  out  1  one-cycle pulse on forced lock release
- o_mem_addr  out  ADDR_W  memory byte address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  4  memory byte mask
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  DATA_W  memory read data (combinational from o_mem_addr)

## Operation
- Handshake: transaction accepted when i_req_valid[k] & o_req_ready[k]. Requester holds all request fields stable until accepted; it may not withdraw valid.
- States: ARB, LOCKED (owner id registered).
- ARB: one valid → grant it. Both valid → grant rr_ptr. After any grant, rr_ptr ← other requester.
- Grant k: o_mem_* driven from requester k in the same cycle; wren = i_req_we[k]. No grant: addr=0, wdata=0, bmask=0, wren=0.
- Accepted with i_req_lock=1 → LOCKED, owner=k, lock_cnt←0. In LOCKED only the owner is granted; the other's o_req_ready=0.
- LOCKED exit: accepted owner transaction with lock=0 → ARB, rr_ptr←other. lock_cnt reaching LOCK_MAX-1 → ARB, rr_ptr←other, o_lock_abort pulse; any owner transaction accepted in that cycle still completes.
- lock_cnt increments every cycle in LOCKED, accepted or not.
- Response: cycle after acceptance, o_rsp_valid[k]=1. Read: o_rsp_rdata[k] = i_mem_rdata sampled in the grant cycle. Write: rdata=0.
- bmask=0 write: passed through unchanged, no byte modified, still acknowledged.

## Timing
- Reset (i_reset=0 at edge): state=ARB, rr_ptr=0, lock_cnt=0, all o_rsp_valid/rdata=0, o_lock_abort=0. Responses due on that edge are dropped. o_req_ready=0 while i_reset=0.
- Read latency 1: accept at cycle N, data valid at N+1. Writes commit at the end of cycle N; a read accepted at N+1 sees new data.
- Throughput: one access per cycle. Back-to-back accepts from the same requester allowed when the other is idle.
- Same-cycle write(0)/read(1) to one address: only one granted; order set by rr_ptr. No bypass.
- Address width fixed at ADDR_W; no wrap or range check here.

## Structure
- Package mem_arb_pkg: state enum {ARB, LOCKED}, requester id constants REQ_CORE=0 and REQ_LOADER=1, response struct {valid, rdata}.
- Sub-module rr_arb2: two-way round-robin picker (inputs valid[1:0], rr_ptr, lock/owner mask; output one-hot grant). Everything else is in mem_arbiter.

## Test plan
- Reset then single read from req 0 at addr 0x010 after preloaded 0xDEADBEEF → ready same cycle, rsp_valid[0] next cycle, rdata=0xDEADBEEF.
- Both requesters valid for 4 cycles from reset → grants 0,1,0,1; each rsp_valid pulses exactly twice.
- Req 0 writes 0x11223344 with bmask=4'b0011 to 0x020 over 0xAABBCCDD, then reads → 0xAABB3344 one cycle after read acceptance.
- Req 1 locks and issues 3 writes while req 0 is valid → req 0 ready=0 throughout; clearing lock on 3rd write grants req 0 the next cycle.
- Req 1 holds lock with LOCK_MAX=16 → o_lock_abort pulses at LOCKED cycle 15; req 0 granted the next cycle.
- Read accepted, i_reset=0 on next edge → no rsp_valid; all outputs 0; first post-reset grant goes to req 0.
